// File: rtl/sensor_scan_ctrl_pkg.sv
// Shared types and defaults for the sensor bank scanner: FSM state encoding,
// parameter defaults and a width helper that never returns zero.
package sensor_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ALARM = 2'd2,
        ST_CLEAR = 2'd3
    } scan_state_t;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_SCAN_DIV  = 4;
    localparam int DEF_DEBOUNCE  = 3;
    localparam int BANK_W        = 4;

    // Index width for a range of n values; a single-value range still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_scan_ctrl_err.sv
// Error equation for one 4-bit sensor bank: the primary sensor alone, or the
// secondary sensor confirmed by either tertiary sensor.
module sensor_err_eval
    import sensor_scan_ctrl_pkg::*;
(
    input  logic [BANK_W-1:0] s,
    output logic              err
);

    assign err = s[0] | (s[1] & (s[2] | s[3]));

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Round-robin sensor bank scanner with per-bank debounce, sticky fault flags
// and an IDLE/SCAN/ALARM/CLEAR supervisor FSM.
module sensor_scan_ctrl
    import sensor_scan_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [BANK_W*NUM_BANKS-1:0]        sensors,
    input  logic                               ack,
    output logic [clog2_min1(NUM_BANKS)-1:0]   bank_sel,
    output logic [NUM_BANKS-1:0]               fault,
    output logic                               alarm,
    output logic                               scan_done
);

    localparam int SEL_W = clog2_min1(NUM_BANKS);
    localparam int DIV_W = clog2_min1(SCAN_DIV);
    localparam int CNT_W = clog2_min1(DEBOUNCE + 1);

    localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_BANKS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ARM   = CNT_W'(DEBOUNCE - 1);

    scan_state_t        state;
    scan_state_t        state_next;
    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   div_next;
    logic [SEL_W-1:0]   bank_sel_next;
    logic [CNT_W-1:0]   cnt [NUM_BANKS];

    logic [BANK_W-1:0]  bank_bits;
    logic               bank_err;
    logic               active;
    logic               next_active;
    logic               sample;
    logic               ack_clear;
    logic               fault_set;

    always_comb begin
        bank_bits = sensors[BANK_W*int'(bank_sel) +: BANK_W];
    end

    sensor_err_eval u_err (
        .s   (bank_bits),
        .err (bank_err)
    );

    // NOTE: every always_comb output gets a default before any branch, so no path leaves a latch.
    always_comb begin
        active     = (state == ST_SCAN) || (state == ST_ALARM);
        sample     = active && (div == LAST_DIV);
        ack_clear  = (state == ST_ALARM) && ack;
        fault_set  = sample && bank_err && (cnt[bank_sel] == CNT_ARM);
        state_next = state;

        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (fault_set)    state_next = ST_ALARM;
                else if (!enable) state_next = ST_IDLE;
            end
            ST_ALARM: begin
                if (ack) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_next = enable ? ST_SCAN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Divider and bank pointer run only while staying in SCAN/ALARM; any exit zeroes them.
    always_comb begin
        next_active   = (state_next == ST_SCAN) || (state_next == ST_ALARM);
        div_next      = '0;
        bank_sel_next = '0;
        if (active && next_active) begin
            div_next      = (div == LAST_DIV) ? '0 : div + 1'b1;
            bank_sel_next = bank_sel;
            if (sample) begin
                bank_sel_next = (bank_sel == LAST_BANK) ? '0 : bank_sel + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            div       <= '0;
            bank_sel  <= '0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_next;
            div       <= div_next;
            bank_sel  <= bank_sel_next;
            scan_done <= sample && (bank_sel == LAST_BANK);
        end
    end

    // NOTE: the debounce counters are a small register array holding live state, so they are reset like any flop.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_CLEAR)) begin
            fault <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            if (sample) begin
                if (!bank_err) begin
                    cnt[bank_sel] <= '0;
                end else if (cnt[bank_sel] != CNT_MAX) begin
                    cnt[bank_sel] <= cnt[bank_sel] + 1'b1;
                end
            end
            // An acknowledge on this edge discards any fault that would set with it.
            if (fault_set && !ack_clear) begin
                fault[bank_sel] <= 1'b1;
            end
        end
    end

    assign alarm = (state == ST_ALARM);

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed and randomized bench for sensor_scan_ctrl, compared every cycle
// against a step-count reference model of the scanner.
module tb_sensor_scan_ctrl;

    localparam int NB = 4;
    localparam int SD = 4;
    localparam int DB = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            ack;
    logic [4*NB-1:0] sensors;
    logic [1:0]      bank_sel;
    logic [NB-1:0]   fault;
    logic            alarm;
    logic            scan_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sensor_scan_ctrl #(
        .NUM_BANKS (NB),
        .SCAN_DIV  (SD),
        .DEBOUNCE  (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sensors   (sensors),
        .ack       (ack),
        .bank_sel  (bank_sel),
        .fault     (fault),
        .alarm     (alarm),
        .scan_done (scan_done)
    );

    // Reference model: scan position is a count of active cycles since scanning (re)started.
    typedef enum {M_IDLE, M_RUN, M_ALARM, M_CLEAR} mode_t;
    mode_t         m_mode;
    int            m_step;
    int            m_run [NB];
    logic [NB-1:0] m_fault;
    logic          m_done;

    function automatic logic bank_error(input logic [3:0] s);
        return s[0] || (s[1] && (s[2] || s[3]));
    endfunction

    task automatic model_step();
        bit    act;
        bit    nxt_act;
        bit    is_sample;
        bit    newly;
        int    bank;
        mode_t nxt;
        if (rst) begin
            m_mode  = M_IDLE;
            m_step  = 0;
            m_fault = '0;
            m_done  = 1'b0;
            foreach (m_run[b]) m_run[b] = 0;
            return;
        end
        act       = (m_mode == M_RUN) || (m_mode == M_ALARM);
        bank      = (m_step / SD) % NB;
        is_sample = act && ((m_step % SD) == SD - 1);
        newly     = 1'b0;
        if (m_mode == M_CLEAR) begin
            m_fault = '0;
            foreach (m_run[b]) m_run[b] = 0;
        end else if (is_sample) begin
            if (bank_error(sensors[4*bank +: 4])) begin
                if (m_run[bank] < DB) begin
                    m_run[bank] = m_run[bank] + 1;
                    newly = (m_run[bank] == DB);
                end
            end else begin
                m_run[bank] = 0;
            end
        end
        if (newly && !(m_mode == M_ALARM && ack)) m_fault[bank] = 1'b1;
        case (m_mode)
            M_IDLE:  nxt = enable ? M_RUN : M_IDLE;
            M_RUN:   nxt = newly ? M_ALARM : (enable ? M_RUN : M_IDLE);
            M_ALARM: nxt = ack ? M_CLEAR : M_ALARM;
            default: nxt = enable ? M_RUN : M_IDLE;
        endcase
        nxt_act = (nxt == M_RUN) || (nxt == M_ALARM);
        m_done  = is_sample && (bank == NB - 1);
        m_step  = (act && nxt_act) ? m_step + 1 : 0;
        m_mode  = nxt;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_bank_sel",  32'(bank_sel),  (m_step / SD) % NB);
        check("model_fault",     32'(fault),     32'(m_fault));
        check("model_alarm",     32'(alarm),     32'(m_mode == M_ALARM));
        check("model_scan_done", 32'(scan_done), 32'(m_done));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        ack     = 1'b0;
        sensors = '0;

        // Two reset cycles leave every output at zero.
        run(2);
        check("rst_fault",     32'(fault),     0);
        check("rst_alarm",     32'(alarm),     0);
        check("rst_bank_sel",  32'(bank_sel),  0);
        check("rst_scan_done", 32'(scan_done), 0);

        // Bank 2 primary sensor stuck: third bank-2 sample latches fault 44 clocks into SCAN.
        rst     = 1'b0;
        enable  = 1'b1;
        sensors = 16'h0100;
        cycle();
        for (int k = 1; k <= 44; k++) begin
            cycle();
            check("b2_fault",     32'(fault),     (k == 44) ? 4 : 0);
            check("b2_scan_done", 32'(scan_done), 32'((k == 16) || (k == 32)));
        end
        check("b2_alarm", 32'(alarm), 1);

        // Acknowledge: one CLEAR cycle, then SCAN from bank 0 with faults gone.
        sensors = '0;
        ack     = 1'b1;
        cycle();
        check("clr_alarm",    32'(alarm),    0);
        check("clr_bank_sel", 32'(bank_sel), 0);
        ack = 1'b0;
        cycle();
        check("post_clr_fault",    32'(fault),    0);
        check("post_clr_alarm",    32'(alarm),    0);
        check("post_clr_bank_sel", 32'(bank_sel), 0);

        // Bank 1: clean, two errors, clean, two errors -> counter restarts, no fault.
        sensors = 16'h0020;
        run(5);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        run(10);
        sensors = 16'h00A0;
        run(32);
        sensors = 16'h0000;
        run(16);
        sensors = 16'h00A0;
        run(32);
        check("b1_no_fault", 32'(fault), 0);
        check("b1_no_alarm", 32'(alarm), 0);

        // Bank 3 reaches count 2, enable drops, count survives IDLE.
        sensors = 16'h1000;
        run(32);
        enable = 1'b0;
        cycle();
        check("idle_bank_sel", 32'(bank_sel), 0);
        check("idle_fault",    32'(fault),    0);
        run(2);
        enable = 1'b1;
        cycle();
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("b3_fault", 32'(fault), (k == 16) ? 8 : 0);
        end
        check("b3_alarm", 32'(alarm), 1);

        // Scanning continues in ALARM with enable ignored; bank 0 joins the fault set.
        enable  = 1'b0;
        sensors = 16'h1001;
        for (int i = 0; i < 64 && m_fault != 4'b1001; i++) cycle();
        check("alarm_fault_1001", 32'(fault), 9);
        check("alarm_held",       32'(alarm), 1);

        // Reset in ALARM wins over ack.
        rst = 1'b1;
        ack = 1'b1;
        cycle();
        check("rst2_fault",     32'(fault),     0);
        check("rst2_alarm",     32'(alarm),     0);
        check("rst2_bank_sel",  32'(bank_sel),  0);
        check("rst2_scan_done", 32'(scan_done), 0);
        rst = 1'b0;
        cycle();
        check("rst2_ack_ignored", 32'(alarm), 0);
        ack = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            enable = ($urandom_range(0, 19) != 0);
            if (m_mode == M_ALARM) ack = ($urandom_range(0, 7) == 0);
            else                   ack = ($urandom_range(0, 49) == 0);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 19) == 0) begin
                    sensors[4*b +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
